// File: rtl/gcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gcd_pkg
//  Purpose  : Shared definitions for the GCD arbiter slice: operand width,
//             default watchdog limit, FSM state encoding and a small index
//             helper used by the round-robin picker.
//  Revision : 1.0 - initial release
// ============================================================================
package gcd_pkg;

    localparam int GCD_W           = 32;
    localparam int DEFAULT_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Position 'off' steps above 'base' in a ring of 'n' entries.
    function automatic int wrap_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gcd_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin selector. Searches i_req starting at
//             i_ptr and wrapping, returns the first set bit one-hot and as an
//             index. Outputs are zero when no request is set.
//  Ports    : i_req      [N]  request levels
//             i_ptr      [PW] search start position (0..N-1)
//             o_pick_oh  [N]  one-hot winner
//             o_pick_idx [PW] winner index
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import gcd_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_pick_oh,
    output logic [PW-1:0] o_pick_idx
);

    logic          w_found;
    logic [PW-1:0] w_pos;

    always_comb begin
        o_pick_oh  = '0;
        o_pick_idx = '0;
        w_found    = 1'b0;
        w_pos      = '0;
        for (int i = 0; i < N; i++) begin
            w_pos = PW'(wrap_idx(int'(i_ptr), i, N));
            if (!w_found && i_req[w_pos]) begin
                w_found           = 1'b1;
                o_pick_oh[w_pos]  = 1'b1;
                o_pick_idx        = w_pos;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gcd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : gcd_arbiter
//  Purpose  : Shares a single edge-started GCD engine between N requesters.
//             Round-robin grant, operand capture, one-cycle start pulse,
//             wait for done (with watchdog), one-cycle routed response.
//             A zero operand B is answered directly without the engine.
//  Ports    : clk, resetn (sync, active-low)
//             req[N], req_opa/req_opb[N*W]   requester side
//             gnt[N], rsp_valid[N]           one-hot single-cycle pulses
//             rsp_result[W], rsp_err         response payload (held)
//             busy                           FSM not idle
//             eng_start, eng_opa, eng_opb    engine command side
//             eng_result, eng_done           engine result side
//  Revision : 1.0 - initial release
// ============================================================================
module gcd_arbiter
    import gcd_pkg::*;
#(
    parameter int N       = 4,
    parameter int W       = GCD_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT   // must be >= 2
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] req_opa,
    input  logic [N*W-1:0] req_opb,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   rsp_valid,
    output logic [W-1:0]   rsp_result,
    output logic           rsp_err,
    output logic           busy,
    output logic           eng_start,
    output logic [W-1:0]   eng_opa,
    output logic [W-1:0]   eng_opb,
    input  logic [W-1:0]   eng_result,
    input  logic           eng_done
);

    localparam int PW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT);

    state_t        r_state_q,  w_state_d;
    logic [PW-1:0] r_ptr_q,    w_ptr_d;
    logic [PW-1:0] r_idx_q,    w_idx_d;
    logic [W-1:0]  r_opa_q,    w_opa_d;
    logic [W-1:0]  r_opb_q,    w_opb_d;
    logic [W-1:0]  r_result_q, w_result_d;
    logic          r_err_q,    w_err_d;
    logic [CW-1:0] r_cnt_q,    w_cnt_d;

    logic [N-1:0]  w_pick_oh;
    logic [PW-1:0] w_pick_idx;
    logic [W-1:0]  w_opa_arr [N];
    logic [W-1:0]  w_opb_arr [N];
    logic [W-1:0]  w_sel_opa;
    logic [W-1:0]  w_sel_opb;

    // Unflatten the operand buses so the winner can be selected by index.
    for (genvar g = 0; g < N; g++) begin : g_slice
        assign w_opa_arr[g] = req_opa[g*W +: W];
        assign w_opb_arr[g] = req_opb[g*W +: W];
    end

    assign w_sel_opa = w_opa_arr[w_pick_idx];
    assign w_sel_opb = w_opb_arr[w_pick_idx];

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_rr_pick (
        .i_req      (req),
        .i_ptr      (r_ptr_q),
        .o_pick_oh  (w_pick_oh),
        .o_pick_idx (w_pick_idx)
    );

    always_comb begin
        w_state_d  = r_state_q;
        w_ptr_d    = r_ptr_q;
        w_idx_d    = r_idx_q;
        w_opa_d    = r_opa_q;
        w_opb_d    = r_opb_q;
        w_result_d = r_result_q;
        w_err_d    = r_err_q;
        w_cnt_d    = r_cnt_q;
        case (r_state_q)
            ST_IDLE: begin
                if (|req) begin
                    w_idx_d = w_pick_idx;
                    w_ptr_d = (w_pick_idx == PW'(N-1)) ? '0 : w_pick_idx + PW'(1);
                    w_opa_d = w_sel_opa;
                    w_opb_d = w_sel_opb;
                    // gcd(a,0)=a; the engine would never terminate on b==0.
                    if (w_sel_opb == '0) begin
                        w_result_d = w_sel_opa;
                        w_err_d    = 1'b0;
                        w_state_d  = ST_RESP;
                    end else begin
                        w_state_d  = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                w_cnt_d   = '0;
                w_state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Done has priority over an expiring watchdog.
                if (eng_done) begin
                    w_result_d = eng_result;
                    w_err_d    = 1'b0;
                    w_state_d  = ST_RESP;
                end else if (r_cnt_q == CW'(TIMEOUT-1)) begin
                    w_result_d = '0;
                    w_err_d    = 1'b1;
                    w_state_d  = ST_RESP;
                end else begin
                    w_cnt_d = r_cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                w_cnt_d   = '0;
                w_state_d = ST_IDLE;
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state_q  <= ST_IDLE;
            r_ptr_q    <= '0;
            r_idx_q    <= '0;
            r_opa_q    <= '0;
            r_opb_q    <= '0;
            r_result_q <= '0;
            r_err_q    <= 1'b0;
            r_cnt_q    <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_ptr_q    <= w_ptr_d;
            r_idx_q    <= w_idx_d;
            r_opa_q    <= w_opa_d;
            r_opb_q    <= w_opb_d;
            r_result_q <= w_result_d;
            r_err_q    <= w_err_d;
            r_cnt_q    <= w_cnt_d;
        end
    end

    // Grant is the capture strobe in IDLE; held off while reset is applied.
    assign gnt = (resetn && (r_state_q == ST_IDLE)) ? w_pick_oh : '0;

    always_comb begin
        rsp_valid = '0;
        if (r_state_q == ST_RESP) begin
            rsp_valid[r_idx_q] = 1'b1;
        end
    end

    assign rsp_result = r_result_q;
    assign rsp_err    = r_err_q;
    assign busy       = (r_state_q != ST_IDLE);
    assign eng_start  = (r_state_q == ST_ISSUE);
    assign eng_opa    = r_opa_q;
    assign eng_opb    = r_opb_q;

endmodule
`default_nettype wire

// File: tb/tb_gcd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gcd_arbiter
//  Purpose  : Self-checking bench for gcd_arbiter with a behavioural GCD
//             engine, a round-robin reference model and a response scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gcd_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 16;

    logic           clk    = 1'b0;
    logic           resetn = 1'b0;
    logic [N-1:0]   req    = '0;
    logic [N*W-1:0] req_opa = '0;
    logic [N*W-1:0] req_opb = '0;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_result;
    logic           rsp_err;
    logic           busy;
    logic           eng_start;
    logic [W-1:0]   eng_opa;
    logic [W-1:0]   eng_opb;
    logic [W-1:0]   eng_result;
    logic           eng_done;

    gcd_arbiter #(.N(N), .W(W), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req        (req),
        .req_opa    (req_opa),
        .req_opb    (req_opb),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .eng_start  (eng_start),
        .eng_opa    (eng_opa),
        .eng_opb    (eng_opb),
        .eng_result (eng_result),
        .eng_done   (eng_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a_in, input logic [W-1:0] b_in);
        logic [W-1:0] a, b, t;
        a = a_in;
        b = b_in;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // ---------------- behavioural engine ----------------
    logic hang = 1'b0;
    logic eng_start_d;
    logic eng_run;
    int   eng_cnt;

    always @(posedge clk) begin
        if (!resetn) begin
            eng_done    <= 1'b0;
            eng_result  <= '0;
            eng_run     <= 1'b0;
            eng_cnt     <= 0;
            eng_start_d <= 1'b0;
        end else begin
            eng_start_d <= eng_start;
            if (eng_start && !eng_start_d) begin
                eng_done <= 1'b0;
                eng_run  <= 1'b1;
                eng_cnt  <= int'($urandom_range(0, 5));
            end else if (eng_run && !hang) begin
                if (eng_cnt == 0) begin
                    eng_done   <= 1'b1;
                    eng_result <= ref_gcd(eng_opa, eng_opb);
                    eng_run    <= 1'b0;
                end else begin
                    eng_cnt <= eng_cnt - 1;
                end
            end
        end
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        int           idx;
        logic [W-1:0] res;
        logic         err;
        int           gcyc;
        logic         byp;
    } exp_t;

    exp_t sbq[$];
    int   mptr       = 0;
    int   exp_start  = -1;
    int   last_start = -100;
    int   n_starts   = 0;

    always @(negedge clk) begin
        int           k;
        logic [W-1:0] a, b;
        logic [N-1:0] eoh;
        exp_t         e;
        int           lat;
        if (!resetn) begin
            sbq.delete();
            mptr      = 0;
            exp_start = -1;
        end else begin
            // Grant prediction: first pending requester at or above mptr.
            if (gnt != '0 || (!busy && req != '0)) begin
                k = -1;
                for (int i = 0; i < N; i++) begin
                    if (k < 0 && req[(mptr + i) % N]) k = (mptr + i) % N;
                end
                if (k < 0) begin
                    chk("spurious_gnt", 64'(gnt), 64'(0));
                end else begin
                    eoh    = '0;
                    eoh[k] = 1'b1;
                    chk("gnt_onehot", 64'(gnt), 64'(eoh));
                    a      = req_opa[k*W +: W];
                    b      = req_opb[k*W +: W];
                    mptr   = (k + 1) % N;
                    e.idx  = k;
                    e.byp  = (b == 0);
                    e.err  = !e.byp && hang;
                    e.res  = e.byp ? a : (hang ? '0 : ref_gcd(a, b));
                    e.gcyc = cyc;
                    sbq.push_back(e);
                    if (!e.byp) exp_start = cyc + 1;
                end
            end
            if (eng_start) begin
                n_starts++;
                chk("start_cycle", 64'(cyc), 64'(exp_start));
                chk("start_gap_ge2_low", 64'((cyc - last_start) >= 3), 64'(1));
                last_start = cyc;
                exp_start  = -1;
            end
            if (rsp_valid != '0) begin
                if (sbq.size() == 0) begin
                    chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
                end else begin
                    e          = sbq.pop_front();
                    eoh        = '0;
                    eoh[e.idx] = 1'b1;
                    chk("rsp_valid_route", 64'(rsp_valid), 64'(eoh));
                    chk("rsp_result", 64'(rsp_result), 64'(e.res));
                    chk("rsp_err", 64'(rsp_err), 64'(e.err));
                    lat = cyc - e.gcyc;
                    if (e.byp)      chk("lat_bypass", 64'(lat), 64'(1));
                    else if (e.err) chk("lat_timeout", 64'(lat), 64'(TO + 2));
                    else            chk("lat_engine_ge3", 64'(lat >= 3), 64'(1));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_opa[i*W +: W] = a;
        req_opb[i*W +: W] = b;
        req[i]            = 1'b1;
    endtask

    task automatic wait_gnt(input int i);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (gnt[i] || n >= 300) break;
            n++;
        end
        if (n >= 300) chk("gnt_wait_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
        req[i] = 1'b0;
    endtask

    task automatic request(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk);
        #1;
        set_req(i, a, b);
        wait_gnt(i);
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || sbq.size() != 0 || req != '0) && n < 2000);
        if (n >= 2000) chk("quiet_wait_timeout", 64'(0), 64'(1));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_flags"}, 64'({gnt, rsp_valid, rsp_err, eng_start, busy}), 64'(0));
        chk({tag, "_result"}, 64'(rsp_result), 64'(0));
        chk({tag, "_eng_ops"}, {eng_opa, eng_opb}, 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [N-1:0] g;
        int           s0;
        int           n;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Fairness: all four held continuously, two full rounds.
        set_req(0, 12, 8);
        set_req(1, 35, 14);
        set_req(2, 9, 6);
        set_req(3, 17, 5);
        for (int r = 0; r < 8; r++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (gnt == '0 && n < 300);
            chk("fair_order", 64'(gnt), 64'(1 << (r % N)));
        end
        @(posedge clk);
        #1;
        req = '0;
        wait_quiet();

        // Single request on requester 2.
        request(2, 48, 18);
        wait_quiet();
        chk("single_result", 64'(rsp_result), 64'(6));

        // Bypass cases: no engine start.
        s0 = n_starts;
        request(0, 7, 0);
        wait_quiet();
        chk("bypass_result", 64'(rsp_result), 64'(7));
        request(3, 0, 0);
        wait_quiet();
        chk("bypass_zero_result", 64'(rsp_result), 64'(0));
        chk("bypass_no_start", 64'(n_starts), 64'(s0));

        // Back-to-back from the same requester.
        request(1, 30, 12);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid[1] && n < 300);
        set_req(1, 40, 25);
        wait_gnt(1);
        wait_quiet();
        chk("b2b_result", 64'(rsp_result), 64'(5));

        // Watchdog timeout, then normal service.
        hang = 1'b1;
        request(2, 20, 15);
        wait_quiet();
        chk("timeout_err", 64'(rsp_err), 64'(1));
        chk("timeout_result", 64'(rsp_result), 64'(0));
        hang = 1'b0;
        request(2, 21, 14);
        wait_quiet();
        chk("after_timeout_result", 64'(rsp_result), 64'(7));
        chk("after_timeout_err", 64'(rsp_err), 64'(0));

        // Reset while waiting on a hung engine.
        hang = 1'b1;
        request(0, 100, 75);
        repeat (4) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        hang   = 1'b0;
        @(negedge clk);
        check_zero("mid_wait_reset");
        request(3, 81, 27);
        wait_quiet();
        chk("post_reset_result", 64'(rsp_result), 64'(27));

        // Randomised traffic.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            g = gnt;
            @(posedge clk);
            #1;
            req = req & ~g;
            if (c < 300) begin
                for (int i = 0; i < N; i++) begin
                    if (!req[i] && $urandom_range(0, 3) == 0) begin
                        set_req(i, W'($urandom_range(0, 300)),
                                ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 300)));
                    end
                end
            end
        end
        wait_quiet();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
